// File: rtl/vga_pkg.sv
// Shared constants for the VGA raster scan controller.
// Holds the 640x480@60 Hz timing, the pixel clock divider, the
// frame-buffer scale factor, the 128x96 frame-buffer geometry and
// the counter/address widths derived from them.
package vga_pkg;

  localparam int CLK_DIV      = 4;   // system clocks per VGA pixel
  localparam int SCALE        = 5;   // screen pixels per frame-buffer pixel
  localparam int READ_LATENCY = 2;   // reader clks from address to data, < CLK_DIV

  localparam int H_VISIBLE = 640;
  localparam int H_FP      = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BP      = 48;
  localparam int V_VISIBLE = 480;
  localparam int V_FP      = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BP      = 33;

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;  // 800
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;  // 525

  localparam int FB_WIDTH  = 128;
  localparam int FB_HEIGHT = 96;

  localparam int CNT_W  = $clog2((H_TOTAL > V_TOTAL) ? H_TOTAL : V_TOTAL);
  localparam int ADDR_W = $clog2(FB_WIDTH);
  localparam int SUB_W  = $clog2(SCALE);

endpackage

// File: rtl/vga_scan_ctrl_if.sv
// Address/data bus between the scan controller and the frame-buffer reader.
//   line, offset  : frame-buffer pixel address (controller -> reader)
//   pixel_data    : {R,G,B} for that address   (reader -> controller)
//   valid_pixel   : qualifies pixel_data       (reader -> controller)
// Handshake: there is no ready/backpressure. The address is held for a whole
// pixel tick; the reader must present pixel_data/valid_pixel for it within
// READ_LATENCY clks, and the controller samples both on the next pix_tick.
// A low valid_pixel at that sample point means the pixel is shown black.
interface vga_scan_ctrl_if;
  import vga_pkg::*;

  logic [ADDR_W-1:0] line;
  logic [ADDR_W-1:0] offset;
  logic [2:0]        pixel_data;
  logic              valid_pixel;

  modport master (output line, output offset, input pixel_data, input valid_pixel);
  modport slave  (input line, input offset, output pixel_data, output valid_pixel);

endinterface

// File: rtl/vga_timing.sv
// VGA raster timing: pixel tick divider, horizontal/vertical counters and
// the combinational sync/active decode of the current counter position.
// Ports:
//   clk, reset        : system clock, async active-high reset
//   pix_tick          : one-clk strobe every CLK_DIV clks
//   hcnt, vcnt        : current raster position (the pixel being fetched)
//   h_end, v_end      : counter at its last value (wraps on next tick)
//   active            : position lies in the visible area
//   hsync_n, vsync_n  : active-low sync decoded from the position
module vga_timing
  import vga_pkg::*;
#(
  parameter int H_VIS   = H_VISIBLE,
  parameter int H_FRONT = H_FP,
  parameter int H_PULSE = H_SYNC,
  parameter int H_BACK  = H_BP,
  parameter int V_VIS   = V_VISIBLE,
  parameter int V_FRONT = V_FP,
  parameter int V_PULSE = V_SYNC,
  parameter int V_BACK  = V_BP
) (
  input  logic             clk,
  input  logic             reset,
  output logic             pix_tick,
  output logic [CNT_W-1:0] hcnt,
  output logic [CNT_W-1:0] vcnt,
  output logic             h_end,
  output logic             v_end,
  output logic             active,
  output logic             hsync_n,
  output logic             vsync_n
);

  localparam int HT    = H_VIS + H_FRONT + H_PULSE + H_BACK;
  localparam int VT    = V_VIS + V_FRONT + V_PULSE + V_BACK;
  localparam int DIV_W = $clog2(CLK_DIV);

  logic [DIV_W-1:0] div;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)         div <= '0;
    else if (pix_tick) div <= '0;
    else               div <= div + 1'b1;
  end

  assign pix_tick = (div == DIV_W'(CLK_DIV - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (pix_tick) begin
      if (h_end) begin
        hcnt <= '0;
        vcnt <= v_end ? '0 : vcnt + 1'b1;
      end else begin
        hcnt <= hcnt + 1'b1;
      end
    end
  end

  assign h_end   = (hcnt == CNT_W'(HT - 1));
  assign v_end   = (vcnt == CNT_W'(VT - 1));
  assign active  = (hcnt < CNT_W'(H_VIS)) && (vcnt < CNT_W'(V_VIS));
  assign hsync_n = !((hcnt >= CNT_W'(H_VIS + H_FRONT)) &&
                     (hcnt <  CNT_W'(H_VIS + H_FRONT + H_PULSE)));
  assign vsync_n = !((vcnt >= CNT_W'(V_VIS + V_FRONT)) &&
                     (vcnt <  CNT_W'(V_VIS + V_FRONT + V_PULSE)));

endmodule

// File: rtl/vga_scan_ctrl.sv
// Raster scan controller for the 128x96 3-bit frame-buffer reader.
// Stage 0 (pix_tick): counters move to the next pixel and line/offset are
// updated for it in the same edge. Stage 1 (next pix_tick): the returned
// pixel and the sync decode for that pixel are registered onto the pins,
// so the VGA outputs trail the counters by exactly one pixel tick.
// Ports:
//   clk, reset                   : system clock, async active-high reset
//   rd                           : reader bus (line/offset out, pixel in)
//   vga_red/green/blue           : 4-bit colour, all-ones or zero
//   vga_hsync, vga_vsync         : active-low sync
//   frame_start                  : one-clk pulse when pixel (0,0) is shown
module vga_scan_ctrl
  import vga_pkg::*;
#(
  parameter int H_VIS   = H_VISIBLE,
  parameter int H_FRONT = H_FP,
  parameter int H_PULSE = H_SYNC,
  parameter int H_BACK  = H_BP,
  parameter int V_VIS   = V_VISIBLE,
  parameter int V_FRONT = V_FP,
  parameter int V_PULSE = V_SYNC,
  parameter int V_BACK  = V_BP
) (
  input  logic             clk,
  input  logic             reset,
  vga_scan_ctrl_if.master  rd,
  output logic [3:0]       vga_red,
  output logic [3:0]       vga_green,
  output logic [3:0]       vga_blue,
  output logic             vga_hsync,
  output logic             vga_vsync,
  output logic             frame_start
);

  localparam logic [SUB_W-1:0]  SUB_LAST = SUB_W'(SCALE - 1);
  localparam logic [ADDR_W-1:0] OFF_MAX  = ADDR_W'(FB_WIDTH - 1);
  localparam logic [ADDR_W-1:0] LINE_MAX = ADDR_W'(FB_HEIGHT - 1);

  logic             pix_tick;
  logic [CNT_W-1:0] hcnt;
  logic [CNT_W-1:0] vcnt;
  logic             h_end;
  logic             v_end;
  logic             active;
  logic             hsync_n;
  logic             vsync_n;

  vga_timing #(
    .H_VIS  (H_VIS),   .H_FRONT(H_FRONT), .H_PULSE(H_PULSE), .H_BACK(H_BACK),
    .V_VIS  (V_VIS),   .V_FRONT(V_FRONT), .V_PULSE(V_PULSE), .V_BACK(V_BACK)
  ) u_timing (
    .clk      (clk),
    .reset    (reset),
    .pix_tick (pix_tick),
    .hcnt     (hcnt),
    .vcnt     (vcnt),
    .h_end    (h_end),
    .v_end    (v_end),
    .active   (active),
    .hsync_n  (hsync_n),
    .vsync_n  (vsync_n)
  );

  // Sub-counters track position within the current SCALE-wide cell. They
  // only advance while the next position is still visible, so in blanking
  // the address simply holds its last visible value.
  logic [SUB_W-1:0]  hsub;
  logic [SUB_W-1:0]  vsub;
  logic [ADDR_W-1:0] line_q;
  logic [ADDR_W-1:0] offset_q;
  logic              h_go;
  logic              v_go;
  logic              show;

  assign h_go = (hcnt < CNT_W'(H_VIS - 1));
  assign v_go = (vcnt < CNT_W'(V_VIS - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hsub     <= '0;
      vsub     <= '0;
      line_q   <= '0;
      offset_q <= '0;
    end else if (pix_tick) begin
      if (h_end) begin
        hsub     <= '0;
        offset_q <= '0;
      end else if (h_go) begin
        if (hsub == SUB_LAST) begin
          hsub <= '0;
          if (offset_q != OFF_MAX) offset_q <= offset_q + 1'b1;
        end else begin
          hsub <= hsub + 1'b1;
        end
      end
      // Line address advances at the end of each scan line.
      if (h_end) begin
        if (v_end) begin
          vsub   <= '0;
          line_q <= '0;
        end else if (v_go) begin
          if (vsub == SUB_LAST) begin
            vsub <= '0;
            if (line_q != LINE_MAX) line_q <= line_q + 1'b1;
          end else begin
            vsub <= vsub + 1'b1;
          end
        end
      end
    end
  end

  assign rd.line   = line_q;
  assign rd.offset = offset_q;

  // At pix_tick, active/sync still describe the pixel whose data the reader
  // has been returning during the tick that is just ending.
  assign show = active && rd.valid_pixel;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vga_red     <= 4'h0;
      vga_green   <= 4'h0;
      vga_blue    <= 4'h0;
      vga_hsync   <= 1'b1;
      vga_vsync   <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      frame_start <= pix_tick && (hcnt == '0) && (vcnt == '0);
      if (pix_tick) begin
        vga_red   <= (show && rd.pixel_data[2]) ? 4'hF : 4'h0;
        vga_green <= (show && rd.pixel_data[1]) ? 4'hF : 4'h0;
        vga_blue  <= (show && rd.pixel_data[0]) ? 4'hF : 4'h0;
        vga_hsync <= hsync_n;
        vga_vsync <= vsync_n;
      end
    end
  end

endmodule

// File: tb/tb_vga_scan_ctrl.sv
// Bench for vga_scan_ctrl: one full-size 640x480 instance and one instance
// with a shrunken raster so vertical sync and frame wrap fit a short run.
module tb_vga_scan_ctrl;
  import vga_pkg::*;

  typedef struct { int hv, hfp, hs, hbp, vv, vfp, vs, vbp; } geom_t;
  typedef struct { int n; int offset; int line; int hs; int rgb; } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  vga_scan_ctrl_if fb0 ();
  vga_scan_ctrl_if fb1 ();
  logic [3:0] r0, g0, b0, r1, g1, b1;
  logic       hs0, vs0, fs0, hs1, vs1, fs1;

  vga_scan_ctrl u_full (
    .clk(clk), .reset(reset), .rd(fb0),
    .vga_red(r0), .vga_green(g0), .vga_blue(b0),
    .vga_hsync(hs0), .vga_vsync(vs0), .frame_start(fs0)
  );

  vga_scan_ctrl #(
    .H_VIS(40), .H_FRONT(4), .H_PULSE(6), .H_BACK(10),
    .V_VIS(20), .V_FRONT(2), .V_PULSE(2), .V_BACK(3)
  ) u_small (
    .clk(clk), .reset(reset), .rd(fb1),
    .vga_red(r1), .vga_green(g1), .vga_blue(b1),
    .vga_hsync(hs1), .vga_vsync(vs1), .frame_start(fs1)
  );

  geom_t      g [2];
  string      nm [2];
  int         n, cyc, phase, n_checks, n_pass;
  logic [11:0] exp_rgb [2];
  logic       exp_hs [2], exp_vs [2], exp_fs [2];
  logic       cur_valid [2], cur_mode [2];
  logic [6:0] sh0 [READ_LATENCY], sh1 [READ_LATENCY];
  int         last_hfall, last_vfall, last_fs;
  logic       prev_hs0, prev_vs1;
  vec_t       tbl [18];

  task automatic chk(string name, int act, int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cyc %0d, n %0d)", name, act, exp, cyc, n);
  endtask

  // Address the reader is given for raster position (h,v): the frame-buffer
  // cell it falls in, or the last visible cell once in blanking.
  function automatic int addr_of(int pos, int vis);
    return (pos < vis) ? pos / SCALE : vis / SCALE - 1;
  endfunction

  task automatic check_inst(int i, int line, int offset, logic [11:0] rgb,
                            logic hs, logic vs, logic fs);
    int ht, vt, frame, t, q, hq, vq;
    logic [2:0] pix;
    ht    = g[i].hv + g[i].hfp + g[i].hs + g[i].hbp;
    vt    = g[i].vv + g[i].vfp + g[i].vs + g[i].vbp;
    frame = ht * vt;
    if (reset) begin
      exp_rgb[i] = 12'h000; exp_hs[i] = 1'b1; exp_vs[i] = 1'b1; exp_fs[i] = 1'b0;
    end else begin
      exp_fs[i] = 1'b0;
      if (n > 0 && n % CLK_DIV == 0) begin
        // This tick displays the pixel the counters sat on before it.
        q  = (n / CLK_DIV - 1) % frame;
        hq = q % ht;
        vq = q / ht;
        pix = cur_mode[i] ? 3'b111 : 3'(addr_of(hq, g[i].hv) % 8);
        exp_rgb[i] = (hq < g[i].hv && vq < g[i].vv && cur_valid[i]) ?
                     {{4{pix[2]}}, {4{pix[1]}}, {4{pix[0]}}} : 12'h000;
        exp_hs[i] = !(hq >= g[i].hv + g[i].hfp && hq < g[i].hv + g[i].hfp + g[i].hs);
        exp_vs[i] = !(vq >= g[i].vv + g[i].vfp && vq < g[i].vv + g[i].vfp + g[i].vs);
        exp_fs[i] = (q == 0);
      end
    end
    t = reset ? 0 : (n / CLK_DIV) % frame;
    chk($sformatf("%s.offset", nm[i]), offset, addr_of(t % ht, g[i].hv));
    chk($sformatf("%s.line", nm[i]), line, addr_of(t / ht, g[i].vv));
    chk($sformatf("%s.rgb", nm[i]), int'(rgb), int'(exp_rgb[i]));
    chk($sformatf("%s.hsync", nm[i]), int'(hs), int'(exp_hs[i]));
    chk($sformatf("%s.vsync", nm[i]), int'(vs), int'(exp_vs[i]));
    chk($sformatf("%s.frame_start", nm[i]), int'(fs), int'(exp_fs[i]));
  endtask

  task automatic check_both();
    check_inst(0, int'(fb0.line), int'(fb0.offset), {r0, g0, b0}, hs0, vs0, fs0);
    check_inst(1, int'(fb1.line), int'(fb1.offset), {r1, g1, b1}, hs1, vs1, fs1);
  endtask

  task automatic clear_edges();
    last_hfall = -1; last_vfall = -1; last_fs = -1;
    prev_hs0 = 1'b1; prev_vs1 = 1'b1;
  endtask

  // Multi-cycle timing: hsync period/width on the full raster, vsync
  // period/width and frame_start spacing on the small one.
  task automatic edge_checks();
    if (prev_hs0 && !hs0) begin
      if (last_hfall >= 0) chk("full.hsync_period", cyc - last_hfall, 3200);
      last_hfall = cyc;
    end
    if (!prev_hs0 && hs0 && last_hfall >= 0) chk("full.hsync_low", cyc - last_hfall, 384);
    if (prev_vs1 && !vs1) begin
      if (last_vfall >= 0) chk("small.vsync_period", cyc - last_vfall, 6480);
      last_vfall = cyc;
    end
    if (!prev_vs1 && vs1 && last_vfall >= 0) chk("small.vsync_low", cyc - last_vfall, 480);
    if (fs1) begin
      if (last_fs >= 0) chk("small.frame_period", cyc - last_fs, 6480);
      last_fs = cyc;
    end
    prev_hs0 = hs0;
    prev_vs1 = vs1;
  endtask

  task automatic drive();
    for (int k = READ_LATENCY - 1; k > 0; k--) begin
      sh0[k] = sh0[k-1];
      sh1[k] = sh1[k-1];
    end
    sh0[0] = fb0.offset;
    sh1[0] = fb1.offset;
    for (int i = 0; i < 2; i++) begin
      case (phase)
        0: begin cur_valid[i] = 1'b1; cur_mode[i] = 1'b0; end
        1: begin
          cur_valid[i] = ($urandom_range(0, 3) != 0);
          cur_mode[i]  = ($urandom_range(0, 7) == 0);
        end
        default: begin cur_valid[i] = 1'b0; cur_mode[i] = 1'b1; end
      endcase
    end
    fb0.valid_pixel = cur_valid[0];
    fb0.pixel_data  = cur_mode[0] ? 3'b111 : sh0[READ_LATENCY-1][2:0];
    fb1.valid_pixel = cur_valid[1];
    fb1.pixel_data  = cur_mode[1] ? 3'b111 : sh1[READ_LATENCY-1][2:0];
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    if (!reset) n++;
    @(negedge clk);
    check_both();
    if (!reset) edge_checks();
    if (phase == 0 && !reset) begin
      for (int k = 0; k < 18; k++) begin
        if (tbl[k].n == n) begin
          chk($sformatf("tbl%0d.offset", k), int'(fb0.offset), tbl[k].offset);
          chk($sformatf("tbl%0d.line", k), int'(fb0.line), tbl[k].line);
          chk($sformatf("tbl%0d.hsync", k), int'(hs0), tbl[k].hs);
          chk($sformatf("tbl%0d.rgb", k), int'({r0, g0, b0}), tbl[k].rgb);
        end
      end
    end
    drive();
  endtask

  initial begin
    int guard;
    g[0] = '{H_VISIBLE, H_FP, H_SYNC, H_BP, V_VISIBLE, V_FP, V_SYNC, V_BP};
    g[1] = '{40, 4, 6, 10, 20, 2, 2, 3};
    nm[0] = "full";
    nm[1] = "small";
    // Full raster, reader returns offset[2:0], valid_pixel held high.
    tbl[0]  = '{3,     0,   0, 1, 12'h000};
    tbl[1]  = '{4,     0,   0, 1, 12'h000};
    tbl[2]  = '{20,    1,   0, 1, 12'h000};
    tbl[3]  = '{24,    1,   0, 1, 12'h00F};
    tbl[4]  = '{44,    2,   0, 1, 12'h0F0};
    tbl[5]  = '{64,    3,   0, 1, 12'h0FF};
    tbl[6]  = '{84,    4,   0, 1, 12'hF00};
    tbl[7]  = '{2544,  127, 0, 1, 12'hFFF};
    tbl[8]  = '{2560,  127, 0, 1, 12'hFFF};
    tbl[9]  = '{2564,  127, 0, 1, 12'h000};
    tbl[10] = '{2624,  127, 0, 1, 12'h000};
    tbl[11] = '{2628,  127, 0, 0, 12'h000};
    tbl[12] = '{3008,  127, 0, 0, 12'h000};
    tbl[13] = '{3012,  127, 0, 1, 12'h000};
    tbl[14] = '{3200,  0,   0, 1, 12'h000};
    tbl[15] = '{3204,  0,   0, 1, 12'h000};
    tbl[16] = '{16000, 0,   1, 1, 12'h000};
    tbl[17] = '{16024, 1,   1, 1, 12'h00F};

    n = 0; cyc = 0; phase = 0; n_checks = 0; n_pass = 0;
    for (int k = 0; k < READ_LATENCY; k++) begin sh0[k] = '0; sh1[k] = '0; end
    for (int i = 0; i < 2; i++) begin
      cur_valid[i] = 1'b1; cur_mode[i] = 1'b0;
      exp_rgb[i] = '0; exp_hs[i] = 1'b1; exp_vs[i] = 1'b1; exp_fs[i] = 1'b0;
    end
    fb0.valid_pixel = 1'b1; fb0.pixel_data = 3'b000;
    fb1.valid_pixel = 1'b1; fb1.pixel_data = 3'b000;
    clear_edges();

    // Reset held for 10 clks, released on a falling edge.
    for (int k = 0; k < 10; k++) step();
    reset = 1'b0;

    // Directed: five full lines with a well-behaved reader.
    for (int k = 0; k < 16100; k++) step();

    // Random validity and occasional all-white reader data.
    phase = 1;
    for (int k = 0; k < 16000; k++) step();

    // Reader never valid while returning white: screen must stay black.
    phase = 2;
    for (int k = 0; k < 4000; k++) step();

    // Mid-frame reset on the small raster at vcnt=10, hcnt=30.
    phase = 1;
    guard = 0;
    while (!(((n / CLK_DIV) % 1620) == 630 && (n % CLK_DIV) == 1) && guard < 8000) begin
      step();
      guard++;
    end
    chk("reset_point_reached", int'(guard < 8000), 1);
    @(posedge clk);
    cyc++;
    n++;
    #1 reset = 1'b1;
    n = 0;
    #1 check_both();
    for (int k = 0; k < 3; k++) step();
    reset = 1'b0;
    clear_edges();
    for (int k = 0; k < 300; k++) step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
